// File: rtl/id_decode_stage.sv
// MIPS decode stage: latches fetch output, holds the GPR file, resolves operands
// with EX/MEM/WB forwarding, detects load-use stalls and resolves branches/jumps.
module id_decode_stage #(
  parameter int FS_TO_DS_BUS_WD = 64,
  parameter int DS_TO_ES_BUS_WD = 128,
  parameter int BR_BUS_WD       = 34
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_allowin,
  output logic                       ds_allowin,
  input  logic                       fs_to_ds_valid,
  input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       ds_to_es_valid,
  output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic [BR_BUS_WD-1:0]       br_bus,
  input  logic                       ws_rf_we,
  input  logic [4:0]                 ws_rf_waddr,
  input  logic [31:0]                ws_rf_wdata,
  input  logic                       es_fwd_valid,
  input  logic [4:0]                 es_fwd_dest,
  input  logic [31:0]                es_fwd_data,
  input  logic                       es_is_load,
  input  logic                       ms_fwd_valid,
  input  logic [4:0]                 ms_fwd_dest,
  input  logic [31:0]                ms_fwd_data,
  input  logic                       WS_EX
);

  logic                       ds_valid_q, ds_valid_d;
  logic [FS_TO_DS_BUS_WD-1:0] fs_bus_q, fs_bus_d;
  logic [31:0]                rf_q [32];

  logic [31:0] inst, pc, pc_plus4, br_off, rs_value, rt_value, br_target;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt;
  logic        is_beq, is_bne, is_j, is_jal, is_jr, is_branch;
  logic        rs_used, rt_used, load_use, ds_ready_go, br_taken, br_stall;

  assign inst  = fs_bus_q[63:32];
  assign pc    = fs_bus_q[31:0];
  assign op    = inst[31:26];
  assign funct = inst[5:0];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];

  // Youngest producer wins; WB bypass covers the same-cycle register write.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  src,   input logic [31:0] rf_val,
    input logic        es_v,  input logic [4:0]  es_d, input logic [31:0] es_x,
    input logic        ms_v,  input logic [4:0]  ms_d, input logic [31:0] ms_x,
    input logic        ws_v,  input logic [4:0]  ws_d, input logic [31:0] ws_x);
    if (src == 5'd0)                   return '0;
    else if (es_v && es_d == src)      return es_x;
    else if (ms_v && ms_d == src)      return ms_x;
    else if (ws_v && ws_d == src)      return ws_x;
    else                               return rf_val;
  endfunction

  assign rs_value = fwd_sel(rs, rf_q[rs], es_fwd_valid, es_fwd_dest, es_fwd_data,
                            ms_fwd_valid, ms_fwd_dest, ms_fwd_data,
                            ws_rf_we, ws_rf_waddr, ws_rf_wdata);
  assign rt_value = fwd_sel(rt, rf_q[rt], es_fwd_valid, es_fwd_dest, es_fwd_data,
                            ms_fwd_valid, ms_fwd_dest, ms_fwd_data,
                            ws_rf_we, ws_rf_waddr, ws_rf_wdata);

  assign is_beq    = (op == 6'b000100);
  assign is_bne    = (op == 6'b000101);
  assign is_j      = (op == 6'b000010);
  assign is_jal    = (op == 6'b000011);
  assign is_jr     = (op == 6'b000000) && (funct == 6'b001000);
  assign is_branch = is_beq | is_bne | is_j | is_jal | is_jr;

  assign rs_used = ~(is_j | is_jal);
  assign rt_used = ~(is_j | is_jal | is_jr);

  assign load_use = ds_valid_q & es_fwd_valid & es_is_load & (es_fwd_dest != 5'd0) &
                    ((rs_used & (rs == es_fwd_dest)) | (rt_used & (rt == es_fwd_dest)));

  assign ds_ready_go    = ~load_use;
  assign ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
  assign ds_to_es_valid = ds_valid_q & ds_ready_go;
  assign ds_to_es_bus   = {pc, inst, rs_value, rt_value};

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{inst[15]}}, inst[15:0], 2'b00};

  always_comb begin
    br_target = '0;
    if (is_beq || is_bne)    br_target = pc_plus4 + br_off;
    else if (is_j || is_jal) br_target = {pc_plus4[31:28], inst[25:0], 2'b00};
    else if (is_jr)          br_target = rs_value;
  end

  assign br_taken = ds_valid_q & ds_ready_go & ~WS_EX &
                    (is_j | is_jal | is_jr |
                     (is_beq & (rs_value == rt_value)) |
                     (is_bne & (rs_value != rt_value)));
  assign br_stall = ds_valid_q & ~WS_EX & is_branch & load_use;
  assign br_bus   = {br_stall, br_taken, br_target};

  always_comb begin
    ds_valid_d = ds_valid_q;
    fs_bus_d   = fs_bus_q;
    if (WS_EX)           ds_valid_d = 1'b0;
    else if (ds_allowin) ds_valid_d = fs_to_ds_valid;
    if (fs_to_ds_valid && ds_allowin && !WS_EX) fs_bus_d = fs_to_ds_bus;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q <= 1'b0;
      fs_bus_q   <= '0;
    end else begin
      ds_valid_q <= ds_valid_d;
      fs_bus_q   <= fs_bus_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (ws_rf_we && ws_rf_waddr != 5'd0) begin
      rf_q[ws_rf_waddr] <= ws_rf_wdata;
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: directed scenarios then random traffic,
// expected outputs from an architectural model of the decode stage.
module tb_id_decode_stage;

  logic         clk = 1'b0;
  logic         reset, es_allowin, ds_allowin, fs_to_ds_valid, ds_to_es_valid;
  logic [63:0]  fs_to_ds_bus;
  logic [127:0] ds_to_es_bus;
  logic [33:0]  br_bus;
  logic         ws_rf_we, es_fwd_valid, es_is_load, ms_fwd_valid, WS_EX;
  logic [4:0]   ws_rf_waddr, es_fwd_dest, ms_fwd_dest;
  logic [31:0]  ws_rf_wdata, es_fwd_data, ms_fwd_data;

  always #5 clk = ~clk;

  id_decode_stage #(.FS_TO_DS_BUS_WD(64), .DS_TO_ES_BUS_WD(128), .BR_BUS_WD(34)) dut (
    .clk(clk), .reset(reset), .es_allowin(es_allowin), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus), .br_bus(br_bus),
    .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr), .ws_rf_wdata(ws_rf_wdata),
    .es_fwd_valid(es_fwd_valid), .es_fwd_dest(es_fwd_dest), .es_fwd_data(es_fwd_data),
    .es_is_load(es_is_load), .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest),
    .ms_fwd_data(ms_fwd_data), .WS_EX(WS_EX)
  );

  typedef struct packed {
    logic         v;
    logic         a;
    logic [127:0] bus;
    logic [33:0]  br;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  // Architectural state of the stage
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [31:0] m_inst, m_pc;

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (es_fwd_valid && es_fwd_dest == r) return es_fwd_data;
    if (ms_fwd_valid && ms_fwd_dest == r) return ms_fwd_data;
    if (ws_rf_we && ws_rf_waddr == r) return ws_rf_wdata;
    return m_rf[r];
  endfunction

  task automatic cycle();
    exp_t        e;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt;
    logic [31:0] rsv, rtv, tgt;
    logic        bj, jr, beq, bne, br, lu, taken, stall;
    int          simm;
    op = m_inst[31:26]; funct = m_inst[5:0];
    rs = m_inst[25:21]; rt = m_inst[20:16];
    bj  = (op == 6'd2) || (op == 6'd3);
    jr  = (op == 6'd0) && (funct == 6'd8);
    beq = (op == 6'd4);
    bne = (op == 6'd5);
    br  = bj || jr || beq || bne;
    rsv = m_read(rs);
    rtv = m_read(rt);
    lu = m_valid && es_fwd_valid && es_is_load && es_fwd_dest != 0 &&
         ((!bj && rs == es_fwd_dest) || (!bj && !jr && rt == es_fwd_dest));
    taken = m_valid && !lu && !WS_EX && (bj || jr || (beq && rsv == rtv) || (bne && rsv != rtv));
    stall = m_valid && !WS_EX && br && lu;
    simm = $signed(m_inst[15:0]);
    if (beq || bne) tgt = m_pc + 32'd4 + 32'(simm * 4);
    else if (bj)    tgt = ((m_pc + 32'd4) & 32'hf000_0000) | (32'(m_inst[25:0]) << 2);
    else            tgt = rsv;
    e.v   = m_valid && !lu;
    e.a   = !m_valid || (!lu && es_allowin);
    e.bus = {m_pc, m_inst, rsv, rtv};
    e.br  = {stall, taken, tgt};
    exp_q.push_back(e);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_valid = 1'b0; m_inst = 32'd0; m_pc = 32'd0;
    end else begin
      if (ws_rf_we && ws_rf_waddr != 0) m_rf[ws_rf_waddr] = ws_rf_wdata;
      if (WS_EX) m_valid = 1'b0;
      else if (e.a) begin
        if (fs_to_ds_valid) begin
          m_inst = fs_to_ds_bus[63:32];
          m_pc   = fs_to_ds_bus[31:0];
        end
        m_valid = fs_to_ds_valid;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("ds_to_es_valid", 128'(ds_to_es_valid), 128'(e.v));
      check("ds_allowin", 128'(ds_allowin), 128'(e.a));
      check("ds_to_es_bus", ds_to_es_bus, e.bus);
      check("br_stall_taken", 128'(br_bus[33:32]), 128'(e.br[33:32]));
      if (e.br[32]) check("br_target", 128'(br_bus[31:0]), 128'(e.br[31:0]));
    end
  end

  function automatic logic [31:0] i_addu(input logic [4:0] rd, rs, rt);
    return {6'd0, rs, rt, rd, 5'd0, 6'b100001};
  endfunction
  function automatic logic [31:0] i_br(input logic [5:0] op, input logic [4:0] rs, rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] i_jr(input logic [4:0] rs);
    return {6'd0, rs, 15'd0, 6'b001000};
  endfunction

  task automatic idle();
    reset = 0; es_allowin = 1; fs_to_ds_valid = 0; fs_to_ds_bus = '0;
    ws_rf_we = 0; ws_rf_waddr = 0; ws_rf_wdata = 0;
    es_fwd_valid = 0; es_fwd_dest = 0; es_fwd_data = 0; es_is_load = 0;
    ms_fwd_valid = 0; ms_fwd_dest = 0; ms_fwd_data = 0; WS_EX = 0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    ws_rf_we = 1; ws_rf_waddr = r; ws_rf_wdata = d;
    cycle();
    ws_rf_we = 0;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    fs_to_ds_valid = 1; fs_to_ds_bus = {inst, pc};
    cycle();
    fs_to_ds_valid = 0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] a, b;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 6))
      0: return i_addu(5'($urandom_range(0, 7)), a, b);
      1: return i_br(6'd4, a, b, 16'($urandom));
      2: return i_br(6'd5, a, b, 16'($urandom));
      3: return {6'd2, 26'($urandom)};
      4: return {6'd3, 26'($urandom)};
      5: return i_jr(a);
      default: return {6'b001001, a, b, 16'($urandom)};
    endcase
  endfunction

  initial begin
    idle();
    reset = 1;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_valid = 0; m_inst = 0; m_pc = 0;
    @(posedge clk); #1;
    cycle();
    reset = 0;

    // Reads of a never-written register and BEQ taken / not taken
    issue(i_addu(5'd8, 5'd7, 5'd0), 32'hbfc0_0000); cycle();
    wb(5'd1, 32'd5); wb(5'd2, 32'd5);
    issue(i_br(6'd4, 5'd1, 5'd2, 16'h0003), 32'hbfc0_0010); cycle();
    wb(5'd2, 32'd6);
    issue(i_br(6'd4, 5'd1, 5'd2, 16'h0003), 32'hbfc0_0010); cycle();

    // Load-use stall then release via EX forwarding
    es_fwd_valid = 1; es_fwd_dest = 5'd3; es_is_load = 1; es_fwd_data = 32'hdead;
    issue(i_addu(5'd4, 5'd3, 5'd5), 32'hbfc0_0020); cycle(); cycle();
    es_is_load = 0; es_fwd_data = 32'h1234; cycle();
    es_fwd_valid = 0;
    es_fwd_valid = 1; es_is_load = 1;
    issue(i_br(6'd5, 5'd3, 5'd0, 16'h0001), 32'hbfc0_0030); cycle();
    es_is_load = 0; es_fwd_data = 32'h1234; cycle();
    es_fwd_valid = 0;

    // Forwarding priority with the consumer held by back-pressure
    es_allowin = 0;
    issue(i_addu(5'd1, 5'd4, 5'd0), 32'hbfc0_0040);
    es_fwd_valid = 1; es_fwd_dest = 5'd4; es_fwd_data = 32'h11;
    ms_fwd_valid = 1; ms_fwd_dest = 5'd4; ms_fwd_data = 32'h22;
    ws_rf_we = 1; ws_rf_waddr = 5'd4; ws_rf_wdata = 32'h33;
    cycle();
    es_fwd_valid = 0; cycle();
    ms_fwd_valid = 0; cycle();
    ws_rf_we = 0; es_allowin = 1; cycle();
    wb(5'd0, 32'hffff_ffff);
    issue(i_addu(5'd1, 5'd0, 5'd4), 32'hbfc0_0050); cycle();

    // JR and JAL targets
    wb(5'd31, 32'h8000_1000);
    issue(i_jr(5'd31), 32'hbfc0_0060); cycle();
    issue({6'd3, 26'h000_0040}, 32'hbfc0_0100); cycle();

    // Exception flush beats held instruction and incoming fetch
    es_allowin = 0;
    issue(i_addu(5'd9, 5'd1, 5'd2), 32'hbfc0_0200); cycle();
    WS_EX = 1; fs_to_ds_valid = 1; fs_to_ds_bus = {i_addu(5'd9, 5'd2, 5'd2), 32'hbfc0_0204};
    cycle();
    WS_EX = 0; fs_to_ds_valid = 0; es_allowin = 1; cycle(); cycle();
    es_allowin = 0;
    issue({6'd2, 26'h123_4567}, 32'hbfc0_0300); cycle();
    WS_EX = 1; cycle();
    WS_EX = 0; cycle();
    es_allowin = 1;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      reset          = ($urandom_range(0, 99) < 2);
      es_allowin     = ($urandom_range(0, 3) != 0);
      fs_to_ds_valid = ($urandom_range(0, 9) < 7);
      fs_to_ds_bus   = {rand_inst(), $urandom};
      ws_rf_we       = $urandom_range(0, 1) == 1;
      ws_rf_waddr    = 5'($urandom_range(0, 7));
      ws_rf_wdata    = $urandom;
      es_fwd_valid   = $urandom_range(0, 1) == 1;
      es_fwd_dest    = 5'($urandom_range(0, 7));
      es_fwd_data    = $urandom;
      es_is_load     = ($urandom_range(0, 2) == 0);
      ms_fwd_valid   = $urandom_range(0, 1) == 1;
      ms_fwd_dest    = 5'($urandom_range(0, 7));
      ms_fwd_data    = $urandom;
      WS_EX          = ($urandom_range(0, 19) == 0);
      cycle();
    end
    idle();
    cycle();
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
